eq_gain_sequencer: RTL and testbench

//  Upstream master for the AXI4-Lite manager's simple bus. Holds an 8-band signed gain shadow,

---
 rtl/eq_seq_pkg.sv | 38 +++
 rtl/eq_gain_shadow.sv | 63 ++++++
 rtl/eq_gain_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_eq_gain_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_seq_pkg.sv
// Shared definitions for the equalizer gain sequencer.
//   - Register map of the equalizer block as seen on the simple bus.
//   - FSM state encoding used by eq_gain_sequencer.
//   - Band packing helpers. Eight signed 8-bit gains are packed four per
//     32-bit word. Bands 0..3 go to GAIN_A and bands 4..7 go to GAIN_B.
package eq_seq_pkg;

    localparam int unsigned REG_STATUS = 32'h0;
    localparam int unsigned REG_GAIN_A = 32'h4;
    localparam int unsigned REG_GAIN_B = 32'h8;

    localparam int NUM_BANDS  = 8;
    localparam int GAIN_WIDTH = 8;
    localparam int WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_VERIFY,
        ST_POLL
    } seq_state_t;

    // Word that holds a band: 0 = GAIN_A, 1 = GAIN_B.
    function automatic logic band_word(input logic [2:0] band);
        return band[2];
    endfunction

    // Lowest bit of the band's 8-bit slice inside its word.
    function automatic logic [4:0] band_lsb(input logic [2:0] band);
        return {band[1:0], 3'b000};
    endfunction

    // Bus address of a gain word.
    function automatic int unsigned word_addr(input logic word);
        return word ? REG_GAIN_B : REG_GAIN_A;
    endfunction

endpackage

// File: rtl/eq_gain_shadow.sv
// Shadow copy of the eight equalizer band gains, with one dirty bit per
// packed bus word.
//   clk, reset           clock and synchronous active-high reset
//   upd_valid/band/value gain update. The band slice is written on the next edge.
//   dirty_clr            words the sequencer has just snapshotted
//   dirty_set            words the sequencer must resend (after a timeout)
//   words                the two packed 32-bit gain words, combinational
//   dirty                pending-write flags, one per word
// A set (from an update or from dirty_set) beats a clear in the same cycle.
// This keeps a change that arrives while its word is being snapshotted from
// being lost.
module eq_gain_shadow
    import eq_seq_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       upd_valid,
    input  logic [2:0]                 upd_band,
    input  logic [GAIN_WIDTH-1:0]      upd_value,
    input  logic [1:0]                 dirty_clr,
    input  logic [1:0]                 dirty_set,
    output logic [1:0][WORD_WIDTH-1:0] words,
    output logic [1:0]                 dirty
);

    logic [GAIN_WIDTH-1:0] gains [NUM_BANDS];
    logic [1:0]            upd_mask;

    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        upd_mask = '0;
        if (upd_valid) begin
            upd_mask[band_word(upd_band)] = 1'b1;
        end
    end

    always_comb begin
        words = '0;
        for (int b = 0; b < NUM_BANDS; b++) begin
            words[band_word(3'(b))][band_lsb(3'(b)) +: GAIN_WIDTH] = gains[b];
        end
    end

    // NOTE: the gain array is reset on purpose. Both words are pushed to the
    // equalizer straight after reset, so their contents must be defined zeros.
    // State is updated with non-blocking assignments, so every reader sees
    // the values from before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                gains[b] <= '0;
            end
            dirty <= 2'b11;
        end else begin
            if (upd_valid) begin
                gains[upd_band] <= upd_value;
            end
            dirty <= (dirty & ~dirty_clr) | dirty_set | upd_mask;
        end
    end

endmodule

// File: rtl/eq_gain_sequencer.sv
// Bus master that keeps the equalizer gain registers in step with a local
// shadow. It also polls the equalizer status register.
//   ACLK, ARESET                  clock and synchronous active-high reset
//   gainValid/gainBand/gainValue  gain update. It is always accepted (gainReady=1).
//   clearErr                      clears the sticky applyErr/timeoutErr
//   applyErr                      readback still differed after MAX_RETRY rewrites
//   timeoutErr                    a bus transaction saw no done within TIMEOUT_CYCLES
//   statusWord                    last value read from the status register
//   busy                          sequencer active or a word still pending
//   wrAddr/wrData/wr, wrDone      simple-bus write request and completion
//   rdAddr/rd, rdData/rdDone      simple-bus read request and completion
// All bus outputs are registered. A strobe stays high with stable address and
// data until its done pulse is sampled, and it drops on that same edge.
module eq_gain_sequencer
    import eq_seq_pkg::*;
#(
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int POLL_CYCLES    = 48000,
    parameter int VERIFY         = 1,
    parameter int MAX_RETRY      = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  gainValid,
    input  logic [2:0]            gainBand,
    input  logic [7:0]            gainValue,
    output logic                  gainReady,
    input  logic                  clearErr,
    output logic                  applyErr,
    output logic                  timeoutErr,
    output logic [DATA_WIDTH-1:0] statusWord,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] wrAddr,
    output logic [DATA_WIDTH-1:0] wrData,
    output logic                  wr,
    input  logic                  wrDone,
    output logic [ADDR_WIDTH-1:0] rdAddr,
    output logic                  rd,
    input  logic [DATA_WIDTH-1:0] rdData,
    input  logic                  rdDone
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRY);
    localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_CYCLES - 1);

    seq_state_t                 state;
    logic                       cur_word;
    logic                       pick_word;
    logic [RW-1:0]              retry;
    logic [TW-1:0]              tmo_cnt;
    logic [PW-1:0]              poll_cnt;
    logic                       poll_due;
    logic [1:0]                 dirty;
    logic [1:0]                 dirty_clr;
    logic [1:0]                 dirty_set;
    logic [1:0][WORD_WIDTH-1:0] words;
    logic                       tmo_hit;
    logic                       verify_ok;
    logic                       may_retry;

    assign gainReady = 1'b1;
    // GAIN_A wins when both words are pending.
    assign pick_word = ~dirty[0];
    assign tmo_hit   = (tmo_cnt == TMO_LAST);
    // wrData still holds the snapshot that was written, so it is the reference.
    assign verify_ok = (rdData == wrData);
    assign may_retry = (retry < RETRY_MAX);

    eq_gain_shadow u_shadow (
        .clk       (ACLK),
        .reset     (ARESET),
        .upd_valid (gainValid & gainReady),
        .upd_band  (gainBand),
        .upd_value (gainValue),
        .dirty_clr (dirty_clr),
        .dirty_set (dirty_set),
        .words     (words),
        .dirty     (dirty)
    );

    // A dirty bit is cleared at the edge where its word is snapshotted into
    // wrData. It is set again if the transaction times out, so the word is resent.
    always_comb begin
        dirty_clr = '0;
        dirty_set = '0;
        case (state)
            ST_IDLE: begin
                if (dirty != 2'b00) dirty_clr[pick_word] = 1'b1;
            end
            ST_WRITE: begin
                if (!wrDone && tmo_hit) dirty_set[cur_word] = 1'b1;
            end
            ST_VERIFY: begin
                if (rdDone && !verify_ok && may_retry) dirty_clr[cur_word] = 1'b1;
                if (!rdDone && tmo_hit) dirty_set[cur_word] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state      <= ST_IDLE;
            cur_word   <= 1'b0;
            retry      <= '0;
            tmo_cnt    <= '0;
            poll_cnt   <= POLL_RELOAD;
            poll_due   <= 1'b0;
            wr         <= 1'b0;
            wrAddr     <= '0;
            wrData     <= '0;
            rd         <= 1'b0;
            rdAddr     <= '0;
            applyErr   <= 1'b0;
            timeoutErr <= 1'b0;
            statusWord <= '0;
            busy       <= 1'b0;
        end else begin
            busy <= (state != ST_IDLE) || (dirty != 2'b00);

            // Error sets further down override this clear.
            if (clearErr) begin
                applyErr   <= 1'b0;
                timeoutErr <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    tmo_cnt <= '0;
                    if (dirty != 2'b00) begin
                        cur_word <= pick_word;
                        wrAddr   <= ADDR_WIDTH'(word_addr(pick_word));
                        wrData   <= DATA_WIDTH'(words[pick_word]);
                        wr       <= 1'b1;
                        retry    <= '0;
                        state    <= ST_WRITE;
                    end else if (poll_due) begin
                        rdAddr <= ADDR_WIDTH'(REG_STATUS);
                        rd     <= 1'b1;
                        state  <= ST_POLL;
                    end
                end

                ST_WRITE: begin
                    if (wrDone) begin
                        wr      <= 1'b0;
                        tmo_cnt <= '0;
                        if (VERIFY != 0) begin
                            rdAddr <= wrAddr;
                            rd     <= 1'b1;
                            state  <= ST_VERIFY;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (tmo_hit) begin
                        wr         <= 1'b0;
                        timeoutErr <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                ST_VERIFY: begin
                    if (rdDone) begin
                        rd      <= 1'b0;
                        tmo_cnt <= '0;
                        if (verify_ok) begin
                            state <= ST_IDLE;
                        end else if (may_retry) begin
                            // Rewrite with a fresh snapshot, so the retry also
                            // picks up any update made since the last write.
                            retry  <= retry + RW'(1);
                            wrData <= DATA_WIDTH'(words[cur_word]);
                            wr     <= 1'b1;
                            state  <= ST_WRITE;
                        end else begin
                            applyErr <= 1'b1;
                            state    <= ST_IDLE;
                        end
                    end else if (tmo_hit) begin
                        rd         <= 1'b0;
                        timeoutErr <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                ST_POLL: begin
                    if (rdDone) begin
                        rd         <= 1'b0;
                        statusWord <= rdData;
                        poll_due   <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (tmo_hit) begin
                        // poll_due stays set, so the poll is retried from IDLE.
                        rd         <= 1'b0;
                        timeoutErr <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                default: state <= ST_IDLE;
            endcase

            // The poll timer runs freely. It comes after the FSM so that a new
            // poll request wins over the clear from a poll that is completing.
            if (POLL_CYCLES != 0) begin
                if (poll_cnt == '0) begin
                    poll_cnt <= POLL_RELOAD;
                    poll_due <= 1'b1;
                end else begin
                    poll_cnt <= poll_cnt - PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_eq_gain_sequencer.sv
// Directed bench for eq_gain_sequencer.
// A simple-bus subordinate model answers every request after a fixed latency.
// It stores written words and can corrupt readback or withhold wrDone.
// It logs completed gain-register operations and the start times of status
// polls, and it checks strobe protocol on every cycle.
module tb_eq_gain_sequencer;

    localparam int          BUS_LAT    = 2;
    localparam logic [31:0] STATUS_VAL = 32'hA5A5_0001;

    typedef struct {
        bit          is_wr;
        logic [5:0]  addr;
        logic [31:0] data;
    } op_t;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        gainValid;
    logic [2:0]  gainBand;
    logic [7:0]  gainValue;
    logic        gainReady;
    logic        clearErr;
    logic        applyErr;
    logic        timeoutErr;
    logic [31:0] statusWord;
    logic        busy;
    logic [5:0]  wrAddr;
    logic [31:0] wrData;
    logic        wr;
    logic        wrDone;
    logic [5:0]  rdAddr;
    logic        rd;
    logic [31:0] rdData;
    logic        rdDone;

    bit          withhold_wr;
    bit          corrupt_rd;
    logic [31:0] mem [16];
    op_t         gops[$];
    int          poll_times[$];
    int          cyc;
    int          proto_err;

    int tests_run    = 0;
    int tests_failed = 0;

    eq_gain_sequencer #(
        .ADDR_WIDTH     (6),
        .DATA_WIDTH     (32),
        .POLL_CYCLES    (100),
        .VERIFY         (1),
        .MAX_RETRY      (2),
        .TIMEOUT_CYCLES (256)
    ) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .gainValid  (gainValid),
        .gainBand   (gainBand),
        .gainValue  (gainValue),
        .gainReady  (gainReady),
        .clearErr   (clearErr),
        .applyErr   (applyErr),
        .timeoutErr (timeoutErr),
        .statusWord (statusWord),
        .busy       (busy),
        .wrAddr     (wrAddr),
        .wrData     (wrData),
        .wr         (wr),
        .wrDone     (wrDone),
        .rdAddr     (rdAddr),
        .rd         (rd),
        .rdData     (rdData),
        .rdDone     (rdDone)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_op(input string tag, input int idx, input bit is_wr,
                            input logic [5:0] addr, input logic [31:0] data);
        if (idx >= gops.size()) begin
            check({tag, "_present"}, 32'(gops.size()), 32'(idx + 1));
            return;
        end
        check({tag, "_kind"}, {31'b0, gops[idx].is_wr}, {31'b0, is_wr});
        check({tag, "_addr"}, {26'b0, gops[idx].addr}, {26'b0, addr});
        if (is_wr) check({tag, "_data"}, gops[idx].data, data);
    endtask

    task automatic send_gain(input logic [2:0] band, input logic [7:0] value);
        gainValid = 1'b1;
        gainBand  = band;
        gainValue = value;
        @(negedge ACLK);
        gainValid = 1'b0;
    endtask

    task automatic pulse_clear();
        clearErr = 1'b1;
        @(negedge ACLK);
        clearErr = 1'b0;
        @(negedge ACLK);
    endtask

    task automatic wait_wr(input string tag);
        int n = 0;
        while (!wr && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        check({tag, "_wr_seen"}, {31'b0, wr}, 32'd1);
    endtask

    task automatic wait_quiet(input string tag);
        int n = 0;
        repeat (4) @(negedge ACLK);
        while ((busy || wr || rd) && n < 2000) begin
            @(negedge ACLK);
            n++;
        end
        check({tag, "_quiet"}, {31'b0, busy | wr | rd}, 32'd0);
    endtask

    // Subordinate model and protocol monitor. Inputs change on the falling edge.
    initial begin
        int          wr_wait;
        int          rd_wait;
        bit          wr_q;
        bit          rd_q;
        logic [5:0]  wr_addr_q;
        logic [31:0] wr_data_q;
        logic [5:0]  rd_addr_q;
        logic [31:0] val;
        wr_wait = 0; rd_wait = 0; wr_q = 0; rd_q = 0;
        wr_addr_q = '0; wr_data_q = '0; rd_addr_q = '0;
        cyc = 0; proto_err = 0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        mem[0] = STATUS_VAL;
        wrDone = 1'b0; rdDone = 1'b0; rdData = '0;
        forever begin
            @(negedge ACLK);
            cyc++;
            wrDone = 1'b0; rdDone = 1'b0; rdData = '0;
            if (ARESET) begin
                wr_wait = 0; rd_wait = 0; wr_q = 0; rd_q = 0;
            end else begin
                if (wr && rd) proto_err++;
                if (wr && wr_q && (wrAddr !== wr_addr_q || wrData !== wr_data_q)) proto_err++;
                if (rd && rd_q && rdAddr !== rd_addr_q) proto_err++;
                if (rd && !rd_q && rdAddr == 6'h0) poll_times.push_back(cyc);
                wr_q = wr; rd_q = rd;
                wr_addr_q = wrAddr; wr_data_q = wrData; rd_addr_q = rdAddr;

                if (wr) begin
                    wr_wait++;
                    if (wr_wait >= BUS_LAT && !withhold_wr) begin
                        wrDone = 1'b1;
                        mem[wrAddr[5:2]] = wrData;
                        if (wrAddr != 6'h0) gops.push_back('{1'b1, wrAddr, wrData});
                        wr_wait = 0;
                    end
                end else begin
                    wr_wait = 0;
                end

                if (rd) begin
                    rd_wait++;
                    if (rd_wait >= BUS_LAT) begin
                        val = mem[rdAddr[5:2]];
                        if (corrupt_rd && rdAddr != 6'h0) val = ~val;
                        rdData = val;
                        rdDone = 1'b1;
                        if (rdAddr != 6'h0) gops.push_back('{1'b0, rdAddr, val});
                        rd_wait = 0;
                    end
                end else begin
                    rd_wait = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of run, expected finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;
        ARESET = 1'b1; gainValid = 1'b0; gainBand = '0; gainValue = '0;
        clearErr = 1'b0; withhold_wr = 1'b0; corrupt_rd = 1'b0;
        repeat (3) @(negedge ACLK);

        // Reset state
        check("rst_wr",         {31'b0, wr},         32'd0);
        check("rst_rd",         {31'b0, rd},         32'd0);
        check("rst_busy",       {31'b0, busy},       32'd0);
        check("rst_apply",      {31'b0, applyErr},   32'd0);
        check("rst_timeout",    {31'b0, timeoutErr}, 32'd0);
        check("rst_status",     statusWord,          32'd0);
        check("rst_gain_ready", {31'b0, gainReady},  32'd1);
        check("rst_wrdata",     wrData,              32'd0);
        ARESET = 1'b0;

        // Full initialisation after reset: both words written and verified.
        wait_quiet("init");
        check_op("init_wr_a", 0, 1'b1, 6'h4, 32'h0);
        check_op("init_rd_a", 1, 1'b0, 6'h4, 32'h0);
        check_op("init_wr_b", 2, 1'b1, 6'h8, 32'h0);
        check_op("init_rd_b", 3, 1'b0, 6'h8, 32'h0);
        check("init_ops", 32'(gops.size()), 32'd4);

        // Band 5 update. Two-cycle latency from accept to wr.
        base = gops.size();
        send_gain(3'd5, 8'hF4);
        check("lat_wr_early", {31'b0, wr}, 32'd0);
        @(negedge ACLK);
        check("lat_wr",   {31'b0, wr},   32'd1);
        check("lat_addr", {26'b0, wrAddr}, 32'h8);
        check("lat_data", wrData,         32'h0000_F400);
        wait_quiet("b5");
        check_op("b5_wr", base,     1'b1, 6'h8, 32'h0000_F400);
        check_op("b5_rd", base + 1, 1'b0, 6'h8, 32'h0);
        check("b5_ops",     32'(gops.size() - base), 32'd2);
        check("b5_apply",   {31'b0, applyErr},       32'd0);
        check("b5_timeout", {31'b0, timeoutErr},     32'd0);

        // Update to the same word while its write is in flight.
        base = gops.size();
        send_gain(3'd0, 8'h7F);
        wait_wr("mid");
        send_gain(3'd1, 8'h10);
        wait_quiet("mid");
        check_op("mid_wr1", base,     1'b1, 6'h4, 32'h0000_007F);
        check_op("mid_rd1", base + 1, 1'b0, 6'h4, 32'h0);
        check_op("mid_wr2", base + 2, 1'b1, 6'h4, 32'h0000_107F);
        check_op("mid_rd2", base + 3, 1'b0, 6'h4, 32'h0);
        check("mid_ops", 32'(gops.size() - base), 32'd4);

        // Readback always wrong: one write plus two retries, then applyErr.
        base = gops.size();
        corrupt_rd = 1'b1;
        send_gain(3'd2, 8'h33);
        wait_quiet("retry");
        corrupt_rd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_op($sformatf("retry_wr%0d", i), base + 2 * i,     1'b1, 6'h4, 32'h0033_107F);
            check_op($sformatf("retry_rd%0d", i), base + 2 * i + 1, 1'b0, 6'h4, 32'h0);
        end
        check("retry_ops",     32'(gops.size() - base), 32'd6);
        check("retry_apply",   {31'b0, applyErr},       32'd1);
        check("retry_timeout", {31'b0, timeoutErr},     32'd0);
        pulse_clear();
        check("clr_apply", {31'b0, applyErr}, 32'd0);

        // Status polling every 100 cycles while idle.
        n = poll_times.size();
        repeat (300) @(negedge ACLK);
        check("poll_seen", {31'b0, (poll_times.size() - n) >= 2}, 32'd1);
        if (poll_times.size() >= 2)
            check("poll_period", 32'(poll_times[$] - poll_times[$-1]), 32'd100);
        wait_quiet("poll");
        check("poll_status", statusWord, STATUS_VAL);

        // wrDone withheld: strobe held for 256 cycles, then timeout and resend.
        base = gops.size();
        withhold_wr = 1'b1;
        send_gain(3'd7, 8'h80);
        wait_wr("tmo");
        n = 0;
        while (wr && n < 400) begin
            n++;
            @(negedge ACLK);
        end
        withhold_wr = 1'b0;
        check("tmo_len",   32'(n),               32'd256);
        check("tmo_err",   {31'b0, timeoutErr}, 32'd1);
        check("tmo_apply", {31'b0, applyErr},   32'd0);
        wait_quiet("tmo");
        check_op("tmo_wr", base,     1'b1, 6'h8, 32'h8000_F400);
        check_op("tmo_rd", base + 1, 1'b0, 6'h8, 32'h0);
        check("tmo_ops",    32'(gops.size() - base), 32'd2);
        check("tmo_sticky", {31'b0, timeoutErr},     32'd1);
        pulse_clear();
        check("clr_timeout", {31'b0, timeoutErr}, 32'd0);

        check("bus_protocol", 32'(proto_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
